score_tracker: RTL and testbench

- Parametrised match scorer: tallies rounds, wins, losses and draws from a per-round result code.
- Runs a best-of/first-to match state machine and declares a match outcome.
- Sits between the per-round comparison logic and the display/score-readout logic.
- Successor to the fixed 4-bit win/lose/round tally; adds draws, a valid strobe, a match-end condition, saturation and a free-running mode.

---
 rtl/score_pkg.sv | 23 ++
 rtl/sat_counter.sv | 25 ++
 rtl/score_tracker.sv | 155 +++++++++++++++
 tb/tb_score_tracker.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// Shared result codes, FSM states and match outcomes
// for the score_tracker slice.
package score_pkg;

  localparam logic [1:0] RES_NONE = 2'b00;
  localparam logic [1:0] RES_DRAW = 2'b01;
  localparam logic [1:0] RES_WIN  = 2'b10;
  localparam logic [1:0] RES_LOSE = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OUT_NONE = 2'b00,
    OUT_TIE  = 2'b01,
    OUT_WIN  = 2'b10,
    OUT_LOSE = 2'b11
  } outcome_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear
// (clear beats increment) and async active-high reset.
module sat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] MAX = '1;

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && count != MAX) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/score_tracker.sv
// Match scorer: tallies round results and runs the
// IDLE/PLAY/DONE match state machine.
module score_tracker
  import score_pkg::*;
#(
  parameter int CNT_W      = 4,
  parameter int WIN_TARGET = 3,
  parameter int MAX_ROUNDS = 5
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             result_valid,
  input  logic [1:0]       matchresult,
  output logic [CNT_W-1:0] round,
  output logic [CNT_W-1:0] win,
  output logic [CNT_W-1:0] lose,
  output logic [CNT_W-1:0] draw,
  output logic             busy,
  output logic             match_over,
  output logic [1:0]       outcome,
  output logic             done_pulse,
  output logic             bad_code
);

  if (MAX_ROUNDS > (2**CNT_W) - 1 ||
      WIN_TARGET > (2**CNT_W) - 1) begin : g_bad_param
    $error("score_tracker: limit exceeds counter range");
  end

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TGT = CNT_W'(WIN_TARGET);
  localparam logic [CNT_W-1:0] LIM = CNT_W'(MAX_ROUNDS);
  localparam bit TGT_EN = (WIN_TARGET != 0);
  localparam bit LIM_EN = (MAX_ROUNDS != 0);

  state_t   state_q;
  outcome_t out_q;
  outcome_t end_out;
  logic     dp_q;
  logic     bad_q;

  logic scoring;
  logic inc_r;
  logic inc_w;
  logic inc_l;
  logic inc_d;
  logic end_w;
  logic end_l;
  logic end_r;
  logic match_end;

  logic [CNT_W-1:0] round_nx;
  logic [CNT_W-1:0] win_nx;
  logic [CNT_W-1:0] lose_nx;

  function automatic logic [CNT_W-1:0] bump(
    input logic [CNT_W-1:0] v,
    input logic             en
  );
    return (en && v != CNT_MAX) ? v + CNT_W'(1) : v;
  endfunction

  // start wins over a same-cycle result
  assign scoring = (state_q == PLAY) && result_valid && !start;
  assign inc_r = scoring && (matchresult != RES_NONE);
  assign inc_w = scoring && (matchresult == RES_WIN);
  assign inc_l = scoring && (matchresult == RES_LOSE);
  assign inc_d = scoring && (matchresult == RES_DRAW);

  assign round_nx = bump(round, inc_r);
  assign win_nx   = bump(win, inc_w);
  assign lose_nx  = bump(lose, inc_l);

  assign end_w = TGT_EN && (win_nx == TGT);
  assign end_l = TGT_EN && (lose_nx == TGT);
  assign end_r = LIM_EN && (round_nx == LIM);
  assign match_end = inc_r && (end_w || end_l || end_r);

  always_comb begin
    end_out = OUT_NONE;
    if (end_w) begin
      end_out = OUT_WIN;
    end else if (end_l) begin
      end_out = OUT_LOSE;
    end else if (end_r) begin
      if (win_nx > lose_nx) begin
        end_out = OUT_WIN;
      end else if (win_nx < lose_nx) begin
        end_out = OUT_LOSE;
      end else begin
        end_out = OUT_TIE;
      end
    end
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state_q <= IDLE;
      out_q   <= OUT_NONE;
      dp_q    <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      dp_q  <= 1'b0;
      bad_q <= scoring && (matchresult == RES_NONE);
      if (start) begin
        state_q <= PLAY;
        out_q   <= OUT_NONE;
      end else if (match_end) begin
        state_q <= DONE;
        out_q   <= end_out;
        dp_q    <= 1'b1;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_round (
    .clk    (clk),
    .resetn (resetn),
    .clr    (start),
    .inc    (inc_r),
    .count  (round)
  );

  sat_counter #(.W(CNT_W)) u_win (
    .clk    (clk),
    .resetn (resetn),
    .clr    (start),
    .inc    (inc_w),
    .count  (win)
  );

  sat_counter #(.W(CNT_W)) u_lose (
    .clk    (clk),
    .resetn (resetn),
    .clr    (start),
    .inc    (inc_l),
    .count  (lose)
  );

  sat_counter #(.W(CNT_W)) u_draw (
    .clk    (clk),
    .resetn (resetn),
    .clr    (start),
    .inc    (inc_d),
    .count  (draw)
  );

  assign busy       = (state_q == PLAY);
  assign match_over = (state_q == DONE);
  assign outcome    = out_q;
  assign done_pulse = dp_q;
  assign bad_code   = bad_q;

endmodule

// File: tb/tb_score_tracker.sv
// Scoreboard bench for score_tracker: default
// best-of-5 instance plus a free-running instance.
module tb_score_tracker;

  logic       clk;
  logic       resetn;
  logic       start;
  logic       result_valid;
  logic [1:0] matchresult;
  logic [3:0] round;
  logic [3:0] win;
  logic [3:0] lose;
  logic [3:0] draw;
  logic       busy;
  logic       match_over;
  logic [1:0] outcome;
  logic       done_pulse;
  logic       bad_code;

  logic       start2;
  logic       valid2;
  logic [1:0] code2;
  logic [3:0] round2;
  logic [3:0] win2;
  logic [3:0] lose2;
  logic [3:0] draw2;
  logic       busy2;
  logic       over2;
  logic [1:0] outcome2;
  logic       dp2;
  logic       bad2;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    string      tag;
    logic [3:0] r;
    logic [3:0] w;
    logic [3:0] l;
    logic [3:0] d;
    logic       busy;
    logic       over;
    logic [1:0] out;
    logic       dp;
    logic       bad;
  } exp_t;

  exp_t sb[$];

  // reference model for the WIN_TARGET=3, MAX_ROUNDS=5 instance
  int m_r;
  int m_w;
  int m_l;
  int m_d;
  int m_st;
  int m_out;
  bit m_dp;
  bit m_bad;

  score_tracker #(
    .CNT_W(4), .WIN_TARGET(3), .MAX_ROUNDS(5)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .start        (start),
    .result_valid (result_valid),
    .matchresult  (matchresult),
    .round        (round),
    .win          (win),
    .lose         (lose),
    .draw         (draw),
    .busy         (busy),
    .match_over   (match_over),
    .outcome      (outcome),
    .done_pulse   (done_pulse),
    .bad_code     (bad_code)
  );

  score_tracker #(
    .CNT_W(4), .WIN_TARGET(0), .MAX_ROUNDS(0)
  ) dut_free (
    .clk          (clk),
    .resetn       (resetn),
    .start        (start2),
    .result_valid (valid2),
    .matchresult  (code2),
    .round        (round2),
    .win          (win2),
    .lose         (lose2),
    .draw         (draw2),
    .busy         (busy2),
    .match_over   (over2),
    .outcome      (outcome2),
    .done_pulse   (dp2),
    .bad_code     (bad2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_r = 0; m_w = 0; m_l = 0; m_d = 0;
    m_st = 0; m_out = 0; m_dp = 0; m_bad = 0;
  endtask

  task automatic model_step(input bit s, input bit v,
                            input logic [1:0] c);
    bit fin;
    m_dp = 0;
    m_bad = 0;
    fin = 0;
    if (s) begin
      m_r = 0; m_w = 0; m_l = 0; m_d = 0;
      m_st = 1; m_out = 0;
    end else if (m_st == 1 && v) begin
      if (c == 2'b00) begin
        m_bad = 1;
      end else begin
        m_r++;
        if (c == 2'b10) m_w++;
        if (c == 2'b11) m_l++;
        if (c == 2'b01) m_d++;
        if (m_w == 3) begin
          m_out = 2; fin = 1;
        end else if (m_l == 3) begin
          m_out = 3; fin = 1;
        end else if (m_r == 5) begin
          fin = 1;
          if (m_w > m_l) m_out = 2;
          else if (m_w < m_l) m_out = 3;
          else m_out = 1;
        end
        if (fin) begin
          m_st = 2;
          m_dp = 1;
        end
      end
    end
  endtask

  task automatic step(input bit s, input bit v,
                      input logic [1:0] c,
                      input string tag);
    exp_t e;
    exp_t g;
    start = s;
    result_valid = v;
    matchresult = c;
    model_step(s, v, c);
    e.tag  = tag;
    e.r    = 4'(m_r);
    e.w    = 4'(m_w);
    e.l    = 4'(m_l);
    e.d    = 4'(m_d);
    e.busy = (m_st == 1);
    e.over = (m_st == 2);
    e.out  = 2'(m_out);
    e.dp   = m_dp;
    e.bad  = m_bad;
    sb.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    result_valid = 1'b0;
    matchresult = 2'b00;
    g = sb.pop_front();
    chk({g.tag, ".round"}, 32'(round), 32'(g.r));
    chk({g.tag, ".win"}, 32'(win), 32'(g.w));
    chk({g.tag, ".lose"}, 32'(lose), 32'(g.l));
    chk({g.tag, ".draw"}, 32'(draw), 32'(g.d));
    chk({g.tag, ".busy"}, 32'(busy), 32'(g.busy));
    chk({g.tag, ".over"}, 32'(match_over), 32'(g.over));
    chk({g.tag, ".outcome"}, 32'(outcome), 32'(g.out));
    chk({g.tag, ".done_pulse"}, 32'(done_pulse), 32'(g.dp));
    chk({g.tag, ".bad_code"}, 32'(bad_code), 32'(g.bad));
  endtask

  initial begin
    resetn = 1'b1;
    start = 1'b0;
    result_valid = 1'b0;
    matchresult = 2'b00;
    start2 = 1'b0;
    valid2 = 1'b0;
    code2 = 2'b00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst.round", 32'(round), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.outcome", 32'(outcome), 32'd0);
    resetn = 1'b0;

    step(1'b0, 1'b1, 2'b00, "idle_bad");
    step(1'b0, 1'b1, 2'b10, "idle_win");

    step(1'b1, 1'b0, 2'b00, "t1_start");
    step(1'b0, 1'b1, 2'b10, "t1_w");
    #2;
    resetn = 1'b1;
    #1;
    chk("arst.round", 32'(round), 32'd0);
    chk("arst.win", 32'(win), 32'd0);
    chk("arst.busy", 32'(busy), 32'd0);
    chk("arst.outcome", 32'(outcome), 32'd0);
    #2;
    resetn = 1'b0;
    model_reset();

    step(1'b1, 1'b0, 2'b00, "t2_start");
    step(1'b0, 1'b1, 2'b10, "t2_w1");
    step(1'b0, 1'b1, 2'b10, "t2_w2");
    step(1'b0, 1'b1, 2'b10, "t2_w3");
    step(1'b0, 1'b1, 2'b11, "t2_after");
    step(1'b0, 1'b1, 2'b00, "t2_donebad");

    step(1'b1, 1'b0, 2'b00, "t3_start");
    step(1'b0, 1'b1, 2'b10, "t3_r1");
    step(1'b0, 1'b1, 2'b11, "t3_r2");
    step(1'b0, 1'b1, 2'b01, "t3_r3");
    step(1'b0, 1'b1, 2'b11, "t3_r4");
    step(1'b0, 1'b1, 2'b10, "t3_r5");
    chk("t3.tie", 32'(outcome), 32'd1);
    step(1'b0, 1'b0, 2'b00, "t3_hold");

    step(1'b1, 1'b0, 2'b00, "t4_start");
    step(1'b0, 1'b1, 2'b10, "t4_w1");
    step(1'b0, 1'b1, 2'b10, "t4_w2");
    step(1'b1, 1'b1, 2'b10, "t4_restart");
    step(1'b0, 1'b0, 2'b00, "t4_idle");

    step(1'b0, 1'b1, 2'b00, "t5_bad");
    step(1'b0, 1'b0, 2'b00, "t5_clear");
    step(1'b0, 1'b1, 2'b11, "t5_l1");
    step(1'b0, 1'b1, 2'b11, "t5_l2");
    step(1'b0, 1'b1, 2'b11, "t5_l3");

    start2 = 1'b1;
    @(posedge clk);
    #1;
    start2 = 1'b0;
    chk("fr.busy", 32'(busy2), 32'd1);
    for (int i = 1; i <= 20; i++) begin
      valid2 = 1'b1;
      code2 = 2'b10;
      @(posedge clk);
      #1;
      chk("fr.win", 32'(win2), (i > 15) ? 32'd15 : 32'(i));
      chk("fr.over", 32'(over2), 32'd0);
    end
    valid2 = 1'b0;
    code2 = 2'b00;
    chk("fr.round", 32'(round2), 32'd15);
    chk("fr.lose", 32'(lose2), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
